booth_mult4: RTL
================

# booth_mult4

Sequential signed 4x4 multiplier using the radix-2 Booth algorithm. It feeds the team's 4-bit ripple adder-subtractor stage (mode M=0 add, M=1 subtract; 4-bit sum Y plus two's-complement overflow flag) and consumes its result. It performs one Booth iteration per clock, four iterations in total, and returns an 8-bit two's-complement product. It sits between the operand registers and the result bus of the small arithmetic unit.

## Interface
- No parameters. Operand width is fixed at 4 bits to match the adder-subtractor stage.
- clk  in  1  Single clock. All state changes on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- Start  in  1  Request a multiply. Sampled only in IDLE.
- Mcand  in  4  Multiplicand, signed. Sampled on the accepting edge.
- Mplier  in  4  Multiplier, signed. Sampled on the accepting edge.
- Product  out  8  Signed product, registered. Holds its value until the next completed multiply.
- Busy  out  1  High while in CALC.
- Done  out  1  One-cycle pulse in the DONE state. Product is valid from that cycle onward.

## Operation
- Internal registers:
  - Acc[3:0]: partial high half.
  - Q[3:0]: multiplier / low half.
  - Qm1: Booth extra bit.
  - M[3:0]: latched multiplicand.
  - Cnt[2:0]: iteration counter.
  - State: IDLE, CALC, DONE.
- IDLE, Start=1: load Acc=0, Q=Mplier, Qm1=0, M=Mcand, Cnt=0, then go to CALC.
- IDLE, Start=0: stay in IDLE.
- CALC, one iteration per edge. The adder-subtractor is driven with A=Acc, B=M.
  - {Q[0],Qm1}=00 or 11: no arithmetic. Sum=Acc, sign bit s=Acc[3].
  - {Q[0],Qm1}=01: add (mode 0). Sum=Y, s=Y[3] XOR Ovrflw.
  - {Q[0],Qm1}=10: subtract (mode 1). Sum=Y, s=Y[3] XOR Ovrflw.
  - Arithmetic shift right of {s,Sum,Q} into {Acc,Q,Qm1}:
    - Acc <= {s, Sum[3:1]}
    - Q <= {Sum[0], Q[3:1]}
    - Qm1 <= Q[0]
  - Using s (true sign) rather than Y[3] is mandatory. Without it, the -8 cases give wrong results; for example, 0 - (-8) overflows 4 bits.
  - Cnt increments each iteration. The edge that performs the iteration with Cnt=3 also loads Product <= {Acc_next, Q_next} and moves to DONE.
- DONE: Done=1. The next edge moves unconditionally to IDLE. Start is ignored in DONE and not queued.
- Start asserted in CALC or DONE is ignored. Mcand and Mplier changes during CALC have no effect, because operands are latched.
- Product is not cleared by a new Start. It changes only on the completing edge.
- Full signed range is exact: every product of two values in [-8,7] fits in 8 bits. Maximum is 64 (0x40), minimum is -56 (0xC8).

## Timing
- Reset (asynchronous, immediate, independent of clk):
  - State=IDLE.
  - Acc, Q, Qm1, M, Cnt = 0.
  - Product=8'h00, Busy=0, Done=0.
- Reset asserted mid-CALC aborts the operation. Product returns to 0x00 and no Done pulse is produced.
- Latency: Start accepted at edge E0.
  - Busy is high in the cycles after E0 through E4.
  - Iterations occur at E1..E4.
  - Product updates and Done rises after E4.
  - Done falls after E5.
  - Start -> Done latency is 5 edges. Back-to-back throughput is one multiply per 6 cycles, since a new Start is accepted earliest at the edge after DONE returns to IDLE.
- Busy and Done are decoded from State only, so they are glitch-free registered outputs. Busy and Done are never high simultaneously.
- The adder-subtractor is purely combinational within the CALC cycle. There are no multicycle paths.

## Test plan
- Reset, then Start with Mcand=3, Mplier=5 -> Busy high for 4 cycles, then a single-cycle Done pulse with Product=0x0F.
- Mcand=-8 (1000), Mplier=-8 -> Product=0x40 (64). This exercises subtract overflow and the s=Y[3]^Ovrflw sign correction.
- Mcand=-8, Mplier=7 -> Product=0xC8 (-56). Then Mcand=7, Mplier=-1 -> Product=0xF9 (-7). Product holds 0xC8 until the second Done.
- Exhaustive sweep of all 256 operand pairs, compared against a reference signed multiply:
  - Done appears exactly 5 edges after each accepted Start.
  - Start is re-asserted only in IDLE.
- Hold Start=1 continuously with operands changing every cycle -> multiplies complete every 6 cycles. Each product uses the operands present at its accepting edge; Start during CALC/DONE is ignored.
- Assert rst during the 2nd CALC cycle -> immediate State=IDLE, Busy=0, Product=0x00, and no Done pulse. Deassert rst and Start 2x3 -> Product=0x06.

Source files
------------

// File: rtl/booth_mult4_if.sv
// Operand/result bundle between the arithmetic unit's operand registers,
// the Booth multiplier, and the result bus.
interface booth_mult4_if;
    logic       Start;
    logic [3:0] Mcand;
    logic [3:0] Mplier;
    logic [7:0] Product;
    logic       Busy;
    logic       Done;

    // Requester side: issues operands, observes the result.
    modport master (
        output Start, Mcand, Mplier,
        input  Product, Busy, Done
    );

    // Multiplier side: accepts operands, returns the result.
    modport slave (
        input  Start, Mcand, Mplier,
        output Product, Busy, Done
    );
endinterface

// File: rtl/booth_mult4.sv
// Sequential signed 4x4 radix-2 Booth multiplier. Each multiply takes one
// iteration per clock for four clocks, using a 4-bit adder-subtractor stage,
// and returns an 8-bit two's-complement product.
module booth_mult4 (
    input  logic          clk,
    input  logic          rst,
    booth_mult4_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] acc;
    logic [3:0] q;
    logic       qm1;
    logic [3:0] m;
    logic [2:0] cnt;
    logic [7:0] product;

    // Adder-subtractor stage and Booth step signals.
    logic       mode;
    logic [3:0] b_x;
    logic [3:0] y;
    logic       ovrflw;
    logic [3:0] sum;
    logic       s;
    logic [3:0] acc_next;
    logic [3:0] q_next;

    // Ripple adder-subtractor (A=acc, B=m), then pick the Booth step result.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        mode   = q[0];                      // {Q0,Qm1}=10 subtracts, 01 adds
        b_x    = m ^ {4{mode}};
        y      = acc + b_x + {3'b000, mode};
        ovrflw = (acc[3] == b_x[3]) && (y[3] != acc[3]);
        sum    = acc;
        s      = acc[3];
        if (q[0] ^ qm1) begin
            sum = y;
            // The true sign survives a 4-bit overflow (e.g. 0 - (-8)).
            s   = y[3] ^ ovrflw;
        end
        acc_next = {s, sum[3:1]};
        q_next   = {sum[0], q[3:1]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, four iterations, one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.Start) state_next = CALC;
            CALC:    if (cnt == 3'd3) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, load the product on the last step.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: only a handful of flops here, so all of them are reset; an abort leaves no stale state.
        if (rst) begin
            acc     <= 4'h0;
            q       <= 4'h0;
            qm1     <= 1'b0;
            m       <= 4'h0;
            cnt     <= 3'd0;
            product <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        acc <= 4'h0;
                        q   <= bus.Mplier;
                        qm1 <= 1'b0;
                        m   <= bus.Mcand;
                        cnt <= 3'd0;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    q   <= q_next;
                    qm1 <= q[0];
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd3) begin
                        product <= {acc_next, q_next};
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags decode the state register only.
    assign bus.Busy    = (state == CALC);
    assign bus.Done    = (state == DONE);
    assign bus.Product = product;

endmodule
